// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state type, index-width helper and timeout default for the SPI arbiter
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_START,
    WAIT_END,
    DONE
  } spi_arb_state_e;

  localparam int SPI_DEFAULT_TIMEOUT = 4096;

  // Index width for n requesters; never less than 1 bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/spi_rr_picker.sv
// rtl/spi_rr_picker.sv - combinational round-robin select, scanning upward from last_grant+1
module spi_rr_picker
  import spi_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    logic [IDX_W-1:0] k;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    k     = '0;
    for (int i = 1; i <= N; i++) begin
      k = IDX_W'((int'(last_grant) + i) % N);
      if (!valid && req[k]) begin
        valid  = 1'b1;
        gnt[k] = 1'b1;
        idx    = k;
      end
    end
  end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// rtl/spi_xfer_arbiter.sv - round-robin sharing of one SPI transfer engine among NUM_REQ requesters
// Optional watchdog: define SPI_ARB_TIMEOUT_EN.
module spi_xfer_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = SPI_DEFAULT_TIMEOUT
) (
  input  logic                        PCLK,
  input  logic                        PRESET_n,
  input  logic                        spi_en_i,
  input  logic                        mstr_i,
  input  logic [NUM_REQ-1:0]          req_i,
  input  logic [NUM_REQ*DATA_W-1:0]   wdata_i,
  input  logic                        tip_i,
  input  logic                        receive_data_i,
  input  logic [DATA_W-1:0]           miso_data_i,
  output logic                        send_data_o,
  output logic [DATA_W-1:0]           mosi_data_o,
  output logic [NUM_REQ-1:0]          gnt_o,
  output logic [NUM_REQ-1:0]          done_o,
  output logic [DATA_W-1:0]           rdata_o,
  output logic                        busy_o,
  output logic                        timeout_o
);

  localparam int IDX_W = clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("spi_xfer_arbiter: NUM_REQ must be 2..8");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
    $error("spi_xfer_arbiter: TIMEOUT_CYCLES must be 2..65536");
  end

  spi_arb_state_e       state;
  logic [IDX_W-1:0]     last_grant;
  logic [IDX_W-1:0]     win_idx;
  logic [NUM_REQ-1:0]   pick_gnt;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_valid;
  logic [DATA_W-1:0]    pick_wdata;
  logic                 run;

  assign run = spi_en_i & mstr_i;

  spi_rr_picker #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req        (req_i),
    .last_grant (last_grant),
    .gnt        (pick_gnt),
    .idx        (pick_idx),
    .valid      (pick_valid)
  );

  always_comb begin
    pick_wdata = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick_gnt[k]) pick_wdata = wdata_i[k*DATA_W +: DATA_W];
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  // Arm one cycle early so the pulse lands on the cycle the count reaches TIMEOUT_CYCLES-1.
  localparam logic [15:0] WD_ARM = 16'(TIMEOUT_CYCLES - 2);
  logic [15:0] wd_cnt;
  logic        timeout_q;
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      state       <= IDLE;
      gnt_o       <= '0;
      done_o      <= '0;
      send_data_o <= 1'b0;
      mosi_data_o <= '0;
      rdata_o     <= '0;
      busy_o      <= 1'b0;
      last_grant  <= IDX_W'(NUM_REQ - 1);
      win_idx     <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      wd_cnt      <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      send_data_o <= 1'b0;
      done_o      <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      timeout_q   <= 1'b0;
`endif
      if (state != IDLE && !run) begin
        state  <= IDLE;
        gnt_o  <= '0;
        busy_o <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (run && pick_valid) begin
              state       <= LOAD;
              gnt_o       <= pick_gnt;
              win_idx     <= pick_idx;
              mosi_data_o <= pick_wdata;
              send_data_o <= 1'b1;
              busy_o      <= 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
              wd_cnt      <= '0;
`endif
            end
          end
          LOAD: state <= WAIT_START;
          WAIT_START, WAIT_END: begin
            // A strobe in WAIT_START is a transfer too short for tip to be seen.
            if (receive_data_i) begin
              rdata_o <= miso_data_i;
              done_o  <= gnt_o;
              state   <= DONE;
            end else begin
              if (state == WAIT_START && tip_i) state <= WAIT_END;
`ifdef SPI_ARB_TIMEOUT_EN
              wd_cnt <= wd_cnt + 16'd1;
              if (timeout_q) begin
                state      <= IDLE;
                gnt_o      <= '0;
                busy_o     <= 1'b0;
                last_grant <= win_idx;
              end else if (wd_cnt == WD_ARM) begin
                timeout_q <= 1'b1;
              end
`endif
            end
          end
          DONE: begin
            state      <= IDLE;
            gnt_o      <= '0;
            busy_o     <= 1'b0;
            last_grant <= win_idx;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
